// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: encodings and line-geometry constants shared by the
// memory arbiter and the cache refill engines.
`default_nettype none

package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int LINE_WORDS_DEF = 8;
    localparam int WORD_IDX_W_DEF = $clog2(LINE_WORDS_DEF);

    // Byte-offset width of a line: word index plus the two byte-in-word bits.
    function automatic int line_off_w(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter_pick.sv
// arb_priority_pick: D-over-I selection with a starvation override that hands
// the port to I after STARVE_LIMIT back-to-back D grants while I waits.
`default_nettype none

module arb_priority_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en_i,
    input  logic i_req_i,
    input  logic d_req_i,
    output logic grant_o,
    output logic pick_d_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          w_force_i;

    assign w_force_i = i_req_i && (starve_q == SW'(STARVE_LIMIT));
    assign pick_d_o  = d_req_i && !w_force_i;
    assign grant_o   = grant_en_i && (i_req_i || d_req_i);

    always_comb begin
        starve_d = starve_q;
        if (grant_o) begin
            if (pick_d_o && i_req_i) begin
                starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the main-memory port between ICache and DCache,
// running one whole-line burst per grant followed by a one-cycle done pulse.
`default_nettype none

module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS   = 8,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [31:0]                   i_rdata,
    output logic                          i_rvalid,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [31:0]                   d_wdata,
    output logic [$clog2(LINE_WORDS)-1:0] d_widx,
    output logic [31:0]                   d_rdata,
    output logic                          d_rvalid,
    output logic                          d_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          busy,
    output logic                          owner
);

    localparam int                WIDX_W    = $clog2(LINE_WORDS);
    localparam int                OFF_W     = line_off_w(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    arb_state_e          state_q, state_d;
    logic [WIDX_W-1:0]   cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;

    logic                w_grant, w_pick_d, w_burst, w_rd_beat;
    logic [ADDR_W-1:0]   w_sel_addr;

    arb_priority_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .grant_en_i(state_q == ST_IDLE),
        .i_req_i   (i_req),
        .d_req_i   (d_req),
        .grant_o   (w_grant),
        .pick_d_o  (w_pick_d)
    );

    assign w_sel_addr = w_pick_d ? d_addr : i_addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    owner_d = w_pick_d ? OWNER_D : OWNER_I;
                    we_d    = w_pick_d && d_we;
                    base_d  = w_sel_addr & LINE_MASK;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // The counter wraps to zero naturally on the last word.
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WIDX_W'(LINE_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= OWNER_I;
            we_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            base_q  <= base_d;
        end
    end

    assign w_burst   = (state_q == ST_BURST);
    assign w_rd_beat = w_burst && mem_ack && !we_q;

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign mem_req   = w_burst;
    assign mem_we    = w_burst && we_q;
    assign mem_addr  = base_q + ADDR_W'({cnt_q, 2'b00});
    assign mem_wdata = w_burst ? d_wdata : 32'd0;
    assign d_widx    = cnt_q;

    assign i_rvalid  = w_rd_beat && (owner_q == OWNER_I);
    assign d_rvalid  = w_rd_beat && (owner_q == OWNER_D);
    assign i_rdata   = i_rvalid ? mem_rdata : 32'd0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'd0;
    assign i_done    = (state_q == ST_DONE) && (owner_q == OWNER_I);
    assign d_done    = (state_q == ST_DONE) && (owner_q == OWNER_D);

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench with a cycle-level reference model of
// the arbiter plus literal expectations for each scenario.
`default_nettype none

module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, mem_rdata = '0;
    logic [31:0] d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  d_widx;
    logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we, busy, owner;

    logic [31:0] wb_line [8];
    assign d_wdata = wb_line[d_widx];

    cache_mem_arbiter #(.LINE_WORDS(8), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_widx(d_widx),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: mode 0 acks every cycle (even outside bursts), mode 1 every 3rd cycle, else never.
    int ack_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (cyc % 3 == 0);
            default: mem_ack = 1'b0;
        endcase
        mem_rdata = $urandom;
    end

    // Requesters: hold req until done, then drop it on the edge that ends DONE.
    int i_todo = 0, d_todo = 0;
    always @(posedge clk) begin
        logic iw, dw;
        iw = i_done;
        dw = d_done;
        #1;
        if (iw) begin
            i_todo = (i_todo > 0) ? i_todo - 1 : 0;
            i_req  = (i_todo > 0);
        end
        if (dw) begin
            d_todo = (d_todo > 0) ? d_todo - 1 : 0;
            d_req  = (d_todo > 0);
        end
    end

    // Reference model: phase 0 idle, 1 transferring words, 2 done pulse.
    int          m_phase = 0, m_owner = 0, m_we = 0, m_word = 0, m_starve = 0;
    logic [31:0] m_base = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_we = 0; m_word = 0; m_starve = 0; m_base = '0;
        end else if (m_phase == 0) begin
            if (d_req && !(i_req && m_starve == 4)) begin
                m_owner  = 1;
                m_we     = d_we;
                m_base   = d_addr & 32'hFFFF_FFE0;
                m_starve = i_req ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
                m_word   = 0;
                m_phase  = 1;
            end else if (i_req) begin
                m_owner  = 0;
                m_we     = 0;
                m_base   = i_addr & 32'hFFFF_FFE0;
                m_starve = 0;
                m_word   = 0;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            if (mem_ack) begin
                m_word = m_word + 1;
                if (m_word == 8) begin
                    m_word  = 0;
                    m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        logic xfer, rd;
        xfer = (m_phase == 1);
        rd   = xfer && mem_ack && (m_we == 0);
        check("busy", busy, m_phase != 0);
        check("mem_req", mem_req, xfer);
        if (m_phase != 0) check("owner", owner, m_owner);
        check("i_done", i_done, m_phase == 2 && m_owner == 0);
        check("d_done", d_done, m_phase == 2 && m_owner == 1);
        check("i_rvalid", i_rvalid, rd && m_owner == 0);
        check("d_rvalid", d_rvalid, rd && m_owner == 1);
        if (rd && m_owner == 0) check("i_rdata", i_rdata, mem_rdata);
        if (rd && m_owner == 1) check("d_rdata", d_rdata, mem_rdata);
        if (xfer) begin
            check("mem_addr", mem_addr, m_base + 32'(4 * m_word));
            check("mem_we", mem_we, m_we);
            check("d_widx", d_widx, m_word);
            check("mem_wdata", mem_wdata, wb_line[m_word]);
        end
    end

    // Scenario log for literal expectations.
    logic [31:0] log_addr[$];
    logic        grants[$];
    int          busy_cyc, irv, drv, idone, ddone;
    logic        prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (mem_req && mem_ack) log_addr.push_back(mem_addr);
            if (busy && !prev_busy) grants.push_back(owner);
            if (busy) busy_cyc++;
            if (i_rvalid) irv++;
            if (d_rvalid) drv++;
            if (i_done) idone++;
            if (d_done) ddone++;
            prev_busy = busy;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        grants.delete();
        busy_cyc = 0; irv = 0; drv = 0; idone = 0; ddone = 0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(i_todo == 0 && d_todo == 0 && !busy) && k < budget);
        check({nm, "_timeout"}, k < budget, 1'b1);
    endtask

    task automatic wait_word(input int w, input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(busy && mem_req && d_widx == 3'(w)) && k < 100);
        check({nm, "_timeout"}, k < 100, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) wb_line[k] = 32'hA5A0_0000 + 32'(k * 32'h111);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_owner", owner, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // I-only fill, ack every cycle.
        @(posedge clk); #1;
        clear_log(); ack_mode = 0;
        i_addr = 32'h0000_1234; i_todo = 1; i_req = 1'b1;
        wait_idle(100, "t1");
        check("t1_nacks", log_addr.size(), 8);
        check("t1_addr0", log_addr[0], 32'h1220);
        check("t1_addr7", log_addr[7], 32'h123C);
        check("t1_rvalids", irv, 8);
        check("t1_busy_cycles", busy_cyc, 9);
        check("t1_done", idone, 1);

        // Simultaneous fill requests: D first, then I.
        @(posedge clk); #1;
        clear_log();
        d_we = 1'b0; d_addr = 32'h2000;
        i_todo = 1; d_todo = 1; i_req = 1'b1; d_req = 1'b1;
        wait_idle(200, "t2");
        check("t2_ngrants", grants.size(), 2);
        check("t2_first_D", grants[0], 1'b1);
        check("t2_second_I", grants[1], 1'b0);
        check("t2_d_last", log_addr[7], 32'h201C);
        check("t2_i_first", log_addr[8], 32'h1220);
        check("t2_drv", drv, 8);

        // D writeback with slow memory.
        @(posedge clk); #1;
        clear_log(); ack_mode = 1;
        d_we = 1'b1; d_addr = 32'h3044; d_todo = 1; d_req = 1'b1;
        wait_idle(200, "t3");
        check("t3_nacks", log_addr.size(), 8);
        check("t3_addr0", log_addr[0], 32'h3040);
        check("t3_addr7", log_addr[7], 32'h305C);
        check("t3_no_rvalid", drv, 0);
        check("t3_done", ddone, 1);

        // Starvation: I waits behind repeated D bursts.
        @(posedge clk); #1;
        clear_log(); ack_mode = 0;
        d_we = 1'b0; d_addr = 32'h5000; i_addr = 32'h4000;
        i_todo = 1; d_todo = 6; i_req = 1'b1; d_req = 1'b1;
        wait_idle(500, "t4");
        check("t4_ngrants", grants.size(), 7);
        check("t4_g3_D", grants[3], 1'b1);
        check("t4_g4_I", grants[4], 1'b0);
        check("t4_g5_D", grants[5], 1'b1);

        // Async reset at word 3 abandons the burst.
        @(posedge clk); #1;
        clear_log();
        d_addr = 32'h6000; d_todo = 1; d_req = 1'b1;
        wait_word(3, "t5");
        #2;
        rst = 1'b1;
        #1;
        check("t5_mem_req", mem_req, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_owner", owner, 1'b0);
        d_req = 1'b0; d_todo = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_no_done", ddone, 0);

        // Acks while idle are ignored; a new fill starts at word 0.
        @(posedge clk); #1;
        clear_log();
        repeat (5) @(negedge clk);
        check("t6_idle_busy", busy_cyc, 0);
        check("t6_idle_rvalid", irv + drv, 0);
        @(posedge clk); #1;
        i_addr = 32'h7010; i_todo = 1; i_req = 1'b1;
        wait_idle(100, "t6");
        check("t6_addr0", log_addr[0], 32'h7000);
        check("t6_nacks", log_addr.size(), 8);

        // d_req dropped mid-burst: burst still completes.
        @(posedge clk); #1;
        clear_log();
        d_addr = 32'h8000; d_todo = 1; d_req = 1'b1;
        wait_word(2, "t7");
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_idle(100, "t7");
        check("t7_done", ddone, 1);
        check("t7_nacks", log_addr.size(), 8);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the ICache refill engine and the DCache refill/writeback engine.
- Each requester asks for a whole-line burst. The arbiter grants one requester, sequences LINE_WORDS word transfers over the memory handshake, then signals completion.
- The miss/busy indications feed the ICacheMiss/DCacheMiss inputs of the hazard logic, which stalls the pipeline.

Parameters:
- LINE_WORDS, 8: words per cache line (power of 2, ≥2).
- ADDR_W, 32: byte-address width.
- STARVE_LIMIT, 4: consecutive D bursts allowed while I waits, before I is forced to win.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  ICache line-fill request; held high until i_done
- i_addr  in  ADDR_W  ICache line base address
- i_rdata  out  32  fill word for ICache
- i_rvalid  out  1  i_rdata valid this cycle
- i_done  out  1  one-cycle pulse: ICache burst complete
- d_req  in  1  DCache request; held high until d_done
- d_we  in  1  1 = writeback burst, 0 = fill burst
- d_addr  in  ADDR_W  DCache line base address
- d_wdata  in  32  writeback word indexed by d_widx
- d_widx  out  clog2(LINE_WORDS)  word index DCache must drive on d_wdata
- d_rdata  out  32  fill word for DCache
- d_rvalid  out  1  d_rdata valid this cycle
- d_done  out  1  one-cycle pulse: DCache burst complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word byte-address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory accepted/returned the current word
- mem_rdata  in  32  read data, valid when mem_ack and !mem_we
- busy  out  1  arbiter not IDLE
- owner  out  1  0 = I, 1 = D; meaningful only while busy

Behaviour:
- Reset (async, immediate):
  - state = IDLE, word counter = 0, starve counter = 0.
  - All outputs are 0, including mem_req, done pulses, rvalids and owner.
  - Reset mid-burst abandons the burst; no done pulse is produced.
- States: IDLE, BURST, DONE.
- IDLE:
  - Requests are sampled only here.
  - Both requesting: D wins, unless starve counter == STARVE_LIMIT, in which case I wins.
  - On a grant: latch owner, we (d_we for D, 0 for I) and base address with the low clog2(LINE_WORDS)+2 bits forced to zero; go to BURST.
- BURST:
  - mem_req = 1.
  - mem_addr = base + 4*cnt.
  - mem_we = latched we.
  - mem_wdata = d_wdata.
  - d_widx = cnt.
  - All of these stay stable until mem_ack.
  - On mem_ack with read: owner's rvalid = 1 and rdata = mem_rdata, both combinational in the same cycle.
  - On mem_ack: cnt increments. If cnt == LINE_WORDS-1, cnt wraps to 0 and the state goes to DONE.
  - Without mem_ack: hold.
  - mem_ack may arrive in the first BURST cycle, giving a minimum of 1 cycle per word.
- DONE:
  - Owner's done = 1 for exactly one cycle, mem_req = 0, then return to IDLE.
  - The requester deasserts req on the clock edge ending DONE.
  - Minimum of 1 IDLE cycle between bursts.
- Starve counter, updated on each grant:
  - D granted while i_req is high: increment, saturating at STARVE_LIMIT.
  - I granted: clear to 0.
  - D granted while i_req is low: clear to 0.
- Requester handshake rules:
  - req/addr/we changes during BURST or DONE are ignored; the burst always completes.
  - d_req dropping mid-burst is a protocol error and must not hang the arbiter.
- Outputs:
  - busy = (state != IDLE).
  - Non-owner rvalid/done are always 0.
  - mem_ack outside BURST is ignored.
- Latency: grant is taken on the edge after req is seen in IDLE. Total burst length = 1 + Σ(word wait cycles) + 1 DONE cycle.

Decomposition:
- Shared package: state encoding (IDLE/BURST/DONE), OWNER_I/OWNER_D constants, LINE_WORDS/offset-width localparams shared with the cache modules.
- One natural sub-module, arb_priority_pick: combinational D-over-I pick with starvation override, plus the starve counter register.
- The FSM and word counter stay in the top.

Test Plan:
- I-only fill, LINE_WORDS=8, i_addr=0x0000_1234, mem_ack every cycle:
  - mem_addr = 0x1220, 0x1224 … 0x123C.
  - 8 i_rvalid pulses carrying mem_rdata.
  - i_done one cycle after the 8th ack; busy high for 9 cycles.
- Simultaneous i_req and d_req (d_we=0, d_addr=0x2000): D granted first, I granted after d_done plus 1 IDLE cycle. Every mem_addr is a 0x2000-line address until d_done.
- D writeback (d_we=1), mem_ack every 3rd cycle:
  - mem_we = 1; d_widx steps 0..7.
  - mem_wdata = d_wdata[d_widx], held stable during waits.
  - d_rvalid never asserts.
- Starvation: i_req held high, d_req re-asserted after every d_done. After 4 D bursts the 5th grant is I; the starve counter then reads 0.
- Reset asserted at word 3 of a burst:
  - mem_req, busy and owner drop in the same cycle (async).
  - No done pulse.
  - After release, a new i_req restarts at word 0.
- mem_ack pulsed while in IDLE or DONE: no counter change, no rvalid, no state change.
